program_loader: RTL
===================

Name: program_loader

Overview:
- Upstream feeder for the out-of-order core top level. It takes a program image as a valid/ready word stream and writes it into the core's instruction cache over the core's i_instruction/i_addr/i_wea write port.
- After the image checksum verifies, it asserts the core's start input and counts run cycles.
- It sits between the host/testbench stream source and the core top.

Parameters:
- ADDR_W, 19, width of the i-cache word address (matches the core's i_addr).
- DEPTH, 1024, maximum number of instruction words accepted per image.
- MAGIC, 16'hA55A, required value of header bits [31:16].

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word; combinational from state and reload.
- s_data  in  32  stream word.
- reload  in  1  single-cycle pulse; aborts or clears and returns to IDLE.
- i_instruction  out  32  word to i-cache; drives core i_instruction.
- i_addr  out  ADDR_W  word address to i-cache; drives core i_addr.
- i_wea  out  1  i-cache write enable; drives core i_wea.
- start  out  1  core run enable; drives core start.
- busy  out  1  high in LOAD or CHECK.
- err  out  2  0 none, 1 bad magic, 2 bad count, 3 checksum mismatch.
- loaded_count  out  16  instruction words written for the current image.
- run_cycles  out  32  cycles with start=1 since entering RUN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. i_instruction=0, i_addr=0, i_wea=0, start=0, busy=0, err=0, loaded_count=0, run_cycles=0. s_ready=1 once in IDLE.
- Transfer: occurs on a rising edge with s_valid && s_ready. s_ready = (state in IDLE, LOAD or CHECK) && !reload. s_data is sampled only on a transfer.
- IDLE, header word:
  - cnt = s_data[15:0].
  - s_data[31:16] != MAGIC -> ERROR, err=1.
  - cnt == 0 or cnt > DEPTH -> ERROR, err=2. Magic is checked first.
  - Otherwise latch N=cnt, clear index, loaded_count and sum -> LOAD.
- LOAD, instruction word k (k = 0..N-1):
  - Next cycle: i_wea=1 for exactly one cycle, i_addr=k zero-extended to ADDR_W, i_instruction=s_data. Write latency is 1 cycle.
  - i_instruction and i_addr hold their last values when i_wea=0.
  - sum += s_data, modulo 2^32. loaded_count increments with each i_wea pulse.
  - After word N-1 is accepted -> CHECK.
  - Back-to-back transfers give back-to-back i_wea pulses with no bubble.
- CHECK, checksum word:
  - s_data == sum -> RUN. start=1 from the cycle after this transfer.
  - Otherwise -> ERROR, err=3.
  - The last i_wea pulse always precedes start by at least one cycle.
- RUN:
  - start=1, s_ready=0, busy=0.
  - run_cycles is cleared on entry, increments every cycle start=1, and saturates at 32'hFFFFFFFF.
- ERROR:
  - s_ready=0, start=0. err holds until reload.
- reload, in any state, registered at the next edge:
  - state -> IDLE, start=0, err=0, i_wea=0. No transfer occurs that cycle because s_ready is low.
  - loaded_count and run_cycles hold their values until the next valid header.
  - A reload during LOAD abandons the partial image. Words already written stay in the i-cache.
- Async reset mid-LOAD or mid-RUN: all outputs return to reset values immediately, including i_wea=0 and start=0.
- Stalls: s_valid low for any number of cycles in LOAD or CHECK is legal and changes no state.
- Address width: index is kept at 16 bits and zero-extended to ADDR_W. DEPTH must be ≤ 2^ADDR_W.

Test Plan:
- Nominal load: header 32'hA55A0003, words 32'h00000013, 32'h00100093, 32'h00200113, checksum 32'h003001B9 -> i_wea pulses at addr 0,1,2 with those words; start=1 the cycle after the checksum transfer; loaded_count=3; run_cycles=5 after 5 RUN cycles.
- Bad magic: header 32'h12340002 -> err=1, s_ready=0, start=0, no i_wea; then reload -> err=0, s_ready=1.
- Bad count: headers 32'hA55A0000 and, with DEPTH=1024, 32'hA55A0401 -> err=2 for each. 32'hA55A0400 is accepted and enters LOAD.
- Checksum mismatch: 2-word image 32'h1, 32'h2 with checksum 32'h4 -> both i_wea pulses occur, then err=3 and start stays 0.
- Backpressure and abort:
  - Toggle s_valid randomly through LOAD -> correct addresses and no duplicate writes.
  - Pulse reload after word 1 of 3 -> IDLE; a new valid image then loads from addr 0.
  - Pulse reload together with s_valid=1 -> that word is not consumed.
- Reset and saturation:
  - Assert rst_n=0 mid-RUN -> start=0 immediately, without a clock edge.
  - Force run_cycles to 32'hFFFFFFFE, run 3 cycles -> it holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/program_loader.sv
// Streams a program image into the core's instruction cache, verifies its checksum,
// then enables the core and counts run cycles.
//
// state  | meaning
// IDLE   | waiting for a header word
// LOAD   | accepting instruction words, writing each to the i-cache
// CHECK  | waiting for the checksum word
// RUN    | core enabled, counting run cycles
// ERROR  | image rejected, err valid until reload
module program_loader #(
    parameter int          ADDR_W = 19,
    parameter int          DEPTH  = 1024,
    parameter logic [15:0] MAGIC  = 16'hA55A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              reload,
    output logic [31:0]       i_instruction,
    output logic [ADDR_W-1:0] i_addr,
    output logic              i_wea,
    output logic              start,
    output logic              busy,
    output logic [1:0]        err,
    output logic [15:0]       loaded_count,
    output logic [31:0]       run_cycles
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    logic [2:0]  state;
    logic [15:0] n_words;
    logic [15:0] idx;
    logic [31:0] sum;
    logic [15:0] cnt;
    logic        xfer;

    assign s_ready = ((state == S_IDLE) || (state == S_LOAD) || (state == S_CHECK)) && !reload;
    assign busy    = (state == S_LOAD) || (state == S_CHECK);
    assign xfer    = s_valid && s_ready;
    assign cnt     = s_data[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            n_words       <= '0;
            idx           <= '0;
            sum           <= '0;
            i_instruction <= '0;
            i_addr        <= '0;
            i_wea         <= 1'b0;
            start         <= 1'b0;
            err           <= 2'd0;
            loaded_count  <= '0;
            run_cycles    <= '0;
        end else begin
            i_wea <= 1'b0;
            if (reload) begin
                state <= S_IDLE;
                start <= 1'b0;
                err   <= 2'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (xfer) begin
                            // Magic is checked before the word count.
                            if (s_data[31:16] != MAGIC) begin
                                state <= S_ERROR;
                                err   <= 2'd1;
                            end else if ((cnt == 16'd0) || ({1'b0, cnt} > DEPTH_L)) begin
                                state <= S_ERROR;
                                err   <= 2'd2;
                            end else begin
                                n_words      <= cnt;
                                idx          <= '0;
                                sum          <= '0;
                                loaded_count <= '0;
                                run_cycles   <= '0;
                                state        <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (xfer) begin
                            i_wea         <= 1'b1;
                            i_addr        <= ADDR_W'(idx);
                            i_instruction <= s_data;
                            sum           <= sum + s_data;
                            idx           <= idx + 16'd1;
                            loaded_count  <= loaded_count + 16'd1;
                            if (idx == n_words - 16'd1) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (xfer) begin
                            if (s_data == sum) begin
                                state      <= S_RUN;
                                start      <= 1'b1;
                                run_cycles <= '0;
                            end else begin
                                state <= S_ERROR;
                                err   <= 2'd3;
                            end
                        end
                    end
                    S_RUN: begin
                        if (start && (run_cycles != 32'hFFFF_FFFF)) begin
                            run_cycles <= run_cycles + 32'd1;
                        end
                    end
                    S_ERROR: begin
                        start <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
